dds_chain_seq: RTL

DDS_CHAIN_SEQ -- requirements
Module: dds_chain_seq

---
 rtl/dds_chain_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dds_chain_seq.sv
// Power-up sequencer for the DDS -> noise -> carry-chain datapath with a 32 kHz dt strobe.
// Optional lock-loss monitor: define DDS_LOCK_MON_EN to route PLL unlock into a sticky ERR state.
module dds_chain_seq #(
    parameter int unsigned LOCK_CYC   = 256,
    parameter int unsigned WARMUP_CYC = 1024,
    parameter int unsigned SETTLE_CYC = 4096,
    parameter int unsigned DIV        = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       dds_tvalid,
    input  logic       start,
    input  logic       stop,
    output logic       dds_aclken,
    output logic       noise_en,
    output logic       dt_tick,
    output logic       chain_valid,
    output logic [2:0] state,
    output logic       err
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StDdsWarm  = 3'd2,
        StSettle   = 3'd3,
        StRun      = 3'd4,
        StErr      = 3'd5
    } state_e;

    localparam logic [15:0] LockLim   = 16'(LOCK_CYC);
    localparam logic [15:0] WarmLim   = 16'(WARMUP_CYC);
    localparam logic [15:0] SettleLim = 16'(SETTLE_CYC);
    localparam logic [15:0] DivLast   = 16'(DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0] div_q, div_d;
    logic        div_run;
    logic        lock_lost;
    logic        dds_aclken_q, noise_en_q, chain_valid_q, dt_tick_q;

`ifdef DDS_LOCK_MON_EN
    assign lock_lost = ~locked;
`else
    assign lock_lost = 1'b0;
`endif

    assign cnt_inc = cnt_q + 16'd1;

    // One phase counter serves the lock, warm-up and settle phases in turn.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!locked) begin
                    cnt_d = '0;
                end else if (cnt_inc == LockLim) begin
                    state_d = StDdsWarm;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDdsWarm: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (lock_lost) begin
                    state_d = StErr;
                end else if (dds_tvalid) begin
                    if (cnt_inc == WarmLim) begin
                        state_d = StSettle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StSettle: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (lock_lost) begin
                    state_d = StErr;
                end else if (cnt_inc == SettleLim) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (lock_lost) begin
                    state_d = StErr;
                end
            end
            StErr: begin
                if (stop) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Divider restarts from 0 whenever SETTLE is entered from outside SETTLE/RUN.
    always_comb begin
        div_run = (state_d == StSettle) || (state_d == StRun);
        div_d   = '0;
        if (div_run && ((state_q == StSettle) || (state_q == StRun)) && (div_q != DivLast)) begin
            div_d = div_q + 16'd1;
        end
    end

    // Outputs are decoded from the next state so they move on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            div_q         <= '0;
            dds_aclken_q  <= 1'b0;
            noise_en_q    <= 1'b0;
            chain_valid_q <= 1'b0;
            dt_tick_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            dds_aclken_q  <= state_d inside {StDdsWarm, StSettle, StRun};
            noise_en_q    <= state_d inside {StSettle, StRun};
            chain_valid_q <= (state_d == StRun);
            dt_tick_q     <= div_run && (div_d == DivLast);
        end
    end

`ifdef DDS_LOCK_MON_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == StIdle) && (state_d == StWaitLock)) begin
            err_q <= 1'b0;
        end else if (state_d == StErr) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign state       = state_q;
    assign dds_aclken  = dds_aclken_q;
    assign noise_en    = noise_en_q;
    assign chain_valid = chain_valid_q;
    assign dt_tick     = dt_tick_q;

endmodule
